// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcode/state types and operand-sign helpers for muldiv_unit.
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

  function automatic logic is_signed_a(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_core.sv
// muldiv_seq_core: shared 2*XLEN shift register, adder/subtractor and iteration
// counter for shift-add multiply and restoring radix-2 divide on magnitudes.
`default_nettype none

module muldiv_seq_core #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load,
  input  logic              clear,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]   operand;
  logic              div_mode;
  logic [CNT_W-1:0]  count;

  logic [XLEN-1:0]   upper;
  logic [XLEN:0]     shifted_rem;
  logic [XLEN:0]     lhs;
  logic [XLEN:0]     addend;
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] next_acc;

  assign upper       = acc[2*XLEN-1:XLEN];
  assign shifted_rem = acc[2*XLEN-1:XLEN-1];

  // One adder serves both: upper+multiplicand for mul, shifted_rem-divisor for div.
  assign lhs    = div_mode ? shifted_rem : {1'b0, upper};
  assign addend = div_mode ? ~{1'b0, operand} : {1'b0, operand};
  assign sum    = lhs + addend + {{XLEN{1'b0}}, div_mode};

  always_comb begin
    next_acc = acc;
    if (div_mode) begin
      if (!sum[XLEN])
        next_acc = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        next_acc = {shifted_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      if (acc[0])
        next_acc = {sum, acc[XLEN-1:1]};
      else
        next_acc = {1'b0, upper, acc[XLEN-1:1]};
    end
  end

  assign last = (count == CNT_W'(XLEN - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc      <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
      count    <= '0;
    end else if (load) begin
      acc      <= {{XLEN{1'b0}}, a_mag};
      operand  <= b_mag;
      div_mode <= is_div;
      count    <= '0;
    end else if (clear) begin
      count    <= '0;
    end else if (step) begin
      acc      <= next_acc;
      count    <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M iterative multiply/divide with valid/ready handshakes.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide always iterates.
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o
);

  muldiv_state_e     state;
  muldiv_op_e        op;
  logic [TAG_W-1:0]  tag;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   pending;

  muldiv_op_e        op_in;
  logic              accept;
  logic              div_op;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              overflow;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] acc;
  logic              last;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign op_in  = muldiv_op_e'(req_op_i);
  assign accept = req_valid_i & req_ready_o & ~flush_i;
  assign div_op = req_op_i[2];

  assign neg_a = is_signed_a(op_in) & req_a_i[XLEN-1];
  assign neg_b = is_signed_b(op_in) & req_b_i[XLEN-1];
  assign a_mag = neg_a ? -req_a_i : req_a_i;
  assign b_mag = neg_b ? -req_b_i : req_b_i;

  assign div_zero = div_op & (req_b_i == '0);
  assign overflow = ((op_in == OP_DIV) || (op_in == OP_REM))
                  & (req_a_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (req_b_i == '1);
  assign special  = div_zero | overflow;

  // funct3 bit 1 separates REM/REMU from DIV/DIVU.
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = req_op_i[1] ? req_a_i : '1;
    else if (overflow)
      special_res = req_op_i[1] ? '0 : req_a_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  logic              sx_a;
  logic              sx_b;

  assign sx_a      = is_signed_a(op_in) & req_a_i[XLEN-1];
  assign sx_b      = is_signed_b(op_in) & req_b_i[XLEN-1];
  assign fast_prod = {{XLEN{sx_a}}, req_a_i} * {{XLEN{sx_b}}, req_b_i};
  assign fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

  muldiv_seq_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load   (accept),
    .clear  (flush_i),
    .step   ((state == ST_BUSY) & ~flush_i),
    .is_div (div_op),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .last   (last)
  );

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op)
      OP_MUL:           fix_res = prod_fix[XLEN-1:0];
      OP_DIV, OP_DIVU:  fix_res = quo_fix;
      OP_REM, OP_REMU:  fix_res = rem_fix;
      default:          fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_tag_o   <= '0;
      op           <= OP_MUL;
      tag          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      pending      <= '0;
    end else if (flush_i) begin
      state        <= ST_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready_o <= 1'b0;
            op          <= op_in;
            tag         <= req_tag_i;
            neg_q       <= neg_a ^ neg_b;
            neg_r       <= neg_a;
            if (special) begin
              pending <= special_res;
              state   <= ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!div_op) begin
              pending <= fast_res;
              state   <= ST_DONE;
`endif
            end else begin
              state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (last)
            state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          resp_data_o  <= fix_res;
          resp_tag_o   <= tag;
          resp_valid_o <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          // Direct entries from IDLE publish the pending result one edge later.
          if (!resp_valid_o) begin
            resp_data_o  <= pending;
            resp_tag_o   <= tag;
            resp_valid_o <= 1'b1;
          end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
`default_nettype none

module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [31:0] req_a_i = '0;
  logic [31:0] req_b_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_tag_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_tag_i    (req_tag_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_tag_o   (resp_tag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                        input int lat, input int hold);
    int n;
    @(negedge clk_i);
    req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = t; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check({name, "_ready_low"}, 64'(req_ready_o), 64'd0);
    n = 0;
    while (!resp_valid_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    check({name, "_data"}, 64'(resp_data_o), 64'(exp));
    check({name, "_tag"}, 64'(resp_tag_o), 64'(t));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check({name, "_hold_valid"}, 64'(resp_valid_o), 64'd1);
      check({name, "_hold_data"}, 64'(resp_data_o), 64'(exp));
      check({name, "_hold_tag"}, 64'(resp_tag_o), 64'(t));
      check({name, "_hold_ready"}, 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    check({name, "_consumed"}, 64'(resp_valid_o), 64'd0);
    check({name, "_idle"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    int seen;
    #12;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_valid", 64'(resp_valid_o), 64'd0);
    check("rst_data", 64'(resp_data_o), 64'd0);
    check("rst_tag", 64'(resp_tag_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, MUL_LAT, 0);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, MUL_LAT, 0);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, MUL_LAT, 0);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, MUL_LAT, 0);

    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 5'd7,  32'hFFFFFFFD, DIV_LAT, 0);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 5'd8,  32'hFFFFFFFF, DIV_LAT, 0);
    run_op("divu",   3'd5, 32'd100,      32'd7, 5'd9,  32'd14,       DIV_LAT, 10);
    run_op("remu",   3'd7, 32'd100,      32'd7, 5'd10, 32'd2,        DIV_LAT, 0);

    run_op("div0",   3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, SPC_LAT, 0);
    run_op("rem0",   3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        SPC_LAT, 0);
    run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, SPC_LAT, 0);
    run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        SPC_LAT, 0);

    // Flush in the middle of a divide.
    @(negedge clk_i);
    req_op_i = 3'd4; req_a_i = 32'hFFFFFFF9; req_b_i = 32'd2; req_tag_i = 5'd15; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_idle", 64'(req_ready_o), 64'd1);
    check("flush_valid", 64'(resp_valid_o), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (resp_valid_o) seen = 1;
    end
    check("flush_no_resp", 64'(seen), 64'd0);
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 5'd16, 32'd3, DIV_LAT, 0);

    // Flush and request together: the request is dropped.
    @(negedge clk_i);
    req_op_i = 3'd4; req_a_i = 32'd5; req_b_i = 32'd0; req_tag_i = 5'd17;
    req_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_req_ready", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    check("flush_req_valid", 64'(resp_valid_o), 64'd0);
    check("flush_req_ready2", 64'(req_ready_o), 64'd1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk_i);
    req_op_i = 3'd5; req_a_i = 32'd100; req_b_i = 32'd7; req_tag_i = 5'd18; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready_o), 64'd1);
    check("mid_rst_valid", 64'(resp_valid_o), 64'd0);
    check("mid_rst_data", 64'(resp_data_o), 64'd0);
    check("mid_rst_tag", 64'(resp_tag_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op("b2b_1", 3'd0, 32'd6,   32'd7, 5'd1, 32'd42, MUL_LAT, 0);
    run_op("b2b_2", 3'd5, 32'd100, 32'd7, 5'd2, 32'd14, DIV_LAT, 0);
    run_op("b2b_3", 3'd7, 32'd100, 32'd7, 5'd3, 32'd2,  DIV_LAT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the RV32M/RV64M extension, sitting beside the combinational ALU in the execute stage. It accepts one operation at a time over a valid/ready request port and returns the result plus a passthrough destination tag over a valid/ready response port. Division always iterates. Multiplication is either single-cycle or iterative, selected at compile time. Results follow RISC-V M semantics, including divide-by-zero and signed-overflow cases.

## Interface
- XLEN, 32: operand/result width; even, ≥8.
- TAG_W, 5: width of the passthrough tag (destination register index).

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  pipeline kill; abandons any in-flight operation.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request.
- req_op_i  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a_i  in  XLEN  rs1 operand.
- req_b_i  in  XLEN  rs2 operand.
- req_tag_i  in  TAG_W  tag, returned unchanged.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  consumer takes the result.
- resp_data_o  out  XLEN  result.
- resp_tag_o  out  TAG_W  tag of the result.

## Operation
- States:
  - IDLE: req_ready_o=1.
  - BUSY: iterating.
  - FIXUP: sign correction.
  - DONE: resp_valid_o=1.
- Request acceptance: the handshake req_valid_i & req_ready_o on a rising edge latches the operands, op and tag.
  - Signed operands are converted to magnitudes, and the result sign is recorded.
  - The iteration counter is cleared.
- Transitions:
  - IDLE→BUSY on accept.
  - BUSY→FIXUP after the XLEN-th iteration.
  - FIXUP→DONE.
  - DONE→IDLE when resp_ready_i=1.
- Special cases take IDLE→DONE directly on accept:
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (DIV/REM with a=min signed, b=−1): DIV → a; REM → 0.
- Division: restoring, radix-2, one quotient bit per iteration on a 2·XLEN remainder/quotient register.
- Multiplication (iterative): shift-add, one multiplier bit per iteration, into a 2·XLEN product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Signs: MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned.
- FIXUP: negates the quotient if the operand signs differ; negates the remainder if a was negative. Arithmetic is modulo 2^XLEN.
- flush_i=1: next state IDLE from any state, and any pending result is discarded. If flush_i and an accept coincide, the request is NOT accepted and flush wins.
- resp_data_o/resp_tag_o are held stable while resp_valid_o=1 and resp_ready_i=0.

## Timing
- Reset values: state IDLE, req_ready_o=1, resp_valid_o=0, resp_data_o=0, resp_tag_o=0, counter=0.
- Edge numbering: accept at edge 0.
- Iterative ops: iterations run on edges 1..XLEN, FIXUP runs on edge XLEN+1, and resp_valid_o is high from edge XLEN+1.
- Special cases and fast MUL*: resp_valid_o is high from edge 1.
- Minimum occupancy is 2 cycles. req_ready_o is low from edge 0 until the edge where DONE is consumed.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous); there is no partial response.

## Configuration
- MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle full XLEN×XLEN product. The result is registered at accept, and the state goes IDLE→DONE with resp_valid_o high from edge 1.
- MULDIV_FAST_MUL_EN undefined: multiplies use the iterative path with XLEN+1 latency, identical to division. Division is unaffected in both builds.

## Structure
- Package muldiv_pkg:
  - muldiv_op_e enum, 3-bit, funct3 values.
  - muldiv_state_e enum.
  - Helper function is_signed_a/is_signed_b(op).
- One sub-module, muldiv_seq_core: holds the shared 2·XLEN shift register, adder/subtractor, and counter for iterative mul and div.
- muldiv_unit: holds the FSM, handshakes, sign handling, special cases, and the fast multiplier.

## Test plan
- Multiplies, XLEN=32:
  - MUL a=7, b=0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - Latency: 1 with the macro, 33 without.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2. resp_valid_o is high at edge 33 and tag is echoed.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. All four respond at edge 1.
- Backpressure: hold resp_ready_i=0 for 10 cycles after DONE. Data and tag must stay stable, req_ready_o must stay 0, and the unit returns to IDLE the edge after resp_ready_i=1.
- Flush:
  - flush_i mid-DIV at iteration 10 → IDLE next edge with no response; the next DIVU 9/3 → 3 is correct.
  - flush_i and req_valid_i asserted together → request ignored.
- Reset: assert rst_ni=0 mid-division → outputs return to reset values immediately. After release, back-to-back requests return correct results with tags 1, 2, 3 in order.
